// File: rtl/spi_register_slave.sv
// SPI mode-0 slave that turns 32-bit host frames into synth register writes.
// SPI pins are synchronised into i_Clock; MISO echoes the last accepted frame.
module spi_register_slave #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16
) (
    input  logic                  i_Clock,
    input  logic                  i_Reset,
    input  logic                  i_SPI_SCLK,
    input  logic                  i_SPI_CS_n,
    input  logic                  i_SPI_MOSI,
    output logic                  o_SPI_MISO,
    output logic [ADDR_WIDTH-1:0] o_RegisterNumber,
    output logic [DATA_WIDTH-1:0] o_RegisterValue,
    output logic                  o_RegisterWriteEnable,
    output logic                  o_FrameError
);

    localparam int FRAME_BITS = ADDR_WIDTH + DATA_WIDTH;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] FULL     = CNT_W'(FRAME_BITS);

    localparam logic [1:0] WAIT_CS_HIGH = 2'd0;
    localparam logic [1:0] IDLE         = 2'd1;
    localparam logic [1:0] RECEIVE      = 2'd2;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;

    logic [1:0]            r_state;
    logic [CNT_W-1:0]      r_bit_count;
    logic [FRAME_BITS-1:0] r_rx;
    logic [FRAME_BITS-1:0] r_echo;
    logic [ADDR_WIDTH-1:0] r_number;
    logic [DATA_WIDTH-1:0] r_value;
    logic                  r_write;
    logic                  r_error;

    logic w_sclk_rise;
    logic w_sclk_fall;
    logic w_cs_rise;
    logic w_cs_fall;
    logic w_cs_high;
    logic w_mosi;

    // CS sync resets to "asserted" so a frame already in flight cannot be
    // mistaken for a fresh CS falling edge once reset is released.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_sclk_sync <= '0;
            r_cs_sync   <= '0;
            r_mosi_sync <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_SPI_SCLK};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_SPI_CS_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_SPI_MOSI};
        end
    end

    assign w_sclk_rise = r_sclk_sync[SYNC_STAGES-2] & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_sclk_fall = ~r_sclk_sync[SYNC_STAGES-2] & r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_rise   = r_cs_sync[SYNC_STAGES-2] & ~r_cs_sync[SYNC_STAGES-1];
    assign w_cs_fall   = ~r_cs_sync[SYNC_STAGES-2] & r_cs_sync[SYNC_STAGES-1];
    assign w_cs_high   = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            r_state     <= WAIT_CS_HIGH;
            r_bit_count <= '0;
            r_rx        <= '0;
            r_echo      <= '0;
            r_number    <= '0;
            r_value     <= '0;
            r_write     <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_write <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                WAIT_CS_HIGH: begin
                    if (w_cs_high) begin
                        r_state <= IDLE;
                    end
                end
                IDLE: begin
                    if (w_cs_fall) begin
                        r_echo      <= {r_number, r_value};
                        r_bit_count <= '0;
                        r_state     <= RECEIVE;
                    end
                end
                RECEIVE: begin
                    if (r_bit_count == FULL) begin
                        r_number    <= r_rx[FRAME_BITS-1:DATA_WIDTH];
                        r_value     <= r_rx[DATA_WIDTH-1:0];
                        r_write     <= 1'b1;
                        r_bit_count <= '0;
                        r_echo      <= r_rx;
                        if (w_cs_high) begin
                            r_state <= IDLE;
                        end
                    end else begin
                        if (w_sclk_rise) begin
                            r_rx        <= {r_rx[FRAME_BITS-2:0], w_mosi};
                            r_bit_count <= r_bit_count + CNT_W'(1);
                        end else if (w_sclk_fall && (r_bit_count != '0)) begin
                            // The falling edge that trails a completed frame sees a
                            // zero count and is skipped, keeping the reloaded MSB.
                            r_echo <= {r_echo[FRAME_BITS-2:0], 1'b0};
                        end
                        if (w_cs_rise && !(w_sclk_rise && (r_bit_count == LAST_BIT))) begin
                            if (r_bit_count != '0) begin
                                r_error <= 1'b1;
                            end
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= WAIT_CS_HIGH;
                end
            endcase
        end
    end

    assign o_SPI_MISO            = (r_state == RECEIVE) ? r_echo[FRAME_BITS-1] : 1'b0;
    assign o_RegisterNumber      = r_number;
    assign o_RegisterValue       = r_value;
    assign o_RegisterWriteEnable = r_write;
    assign o_FrameError          = r_error;

endmodule

// File: tb/tb_spi_register_slave.sv
// Scoreboard bench for spi_register_slave: stimulus pushes expected writes and
// error pulses, a monitor pops them whenever the DUT strobes.
module tb_spi_register_slave;

    localparam int H = 40;  // SCLK half period: SCLK = i_Clock / 8

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0;
    logic        csn = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] num;
    logic [15:0] val;
    logic        we;
    logic        ferr;

    int          total = 0;
    int          bad = 0;
    logic [32:0] exp_q[$];
    logic [32:0] mon_e;
    logic [31:0] tb_last = 32'h0;
    logic [31:0] m;

    spi_register_slave #(.SYNC_STAGES(2), .ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
        .i_Clock(clk),
        .i_Reset(rst),
        .i_SPI_SCLK(sclk),
        .i_SPI_CS_n(csn),
        .i_SPI_MOSI(mosi),
        .o_SPI_MISO(miso),
        .o_RegisterNumber(num),
        .o_RegisterValue(val),
        .o_RegisterWriteEnable(we),
        .o_FrameError(ferr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %08h want %08h", name, got, want);
        end else begin
            $display("ok   %s: %08h", name, got);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (we || ferr)) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_event: got we=%0b err=%0b num=%04h val=%04h want none",
                         we, ferr, num, val);
            end else begin
                mon_e = exp_q.pop_front();
                check("event_is_error", 32'(ferr), 32'(mon_e[32]));
                if (!mon_e[32]) check("write_frame", {num, val}, mon_e[31:0]);
            end
        end
    end

    task automatic spi_bits(input logic [31:0] data, input int n, output logic [31:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            mosi = data[31-i];
            #(H);
            sclk = 1'b1;
            rx = {rx[30:0], miso};
            #(H);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_low();
        csn = 1'b0;
        #(H);
    endtask

    task automatic cs_high();
        #(H);
        csn = 1'b1;
        #(2*H);
    endtask

    // Full frame inside an already-asserted CS; MISO must echo the previous frame.
    task automatic full_frame(input logic [31:0] data);
        logic [31:0] prev;
        logic [31:0] echo;
        prev = tb_last;
        tb_last = data;
        exp_q.push_back({1'b0, data});
        spi_bits(data, 32, echo);
        check("miso_echo", echo, prev);
    endtask

    initial begin
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_number", 32'(num), 32'h0);
        check("reset_value", 32'(val), 32'h0);
        check("reset_we", 32'(we), 32'h0);
        check("reset_err", 32'(ferr), 32'h0);
        check("reset_miso", 32'(miso), 32'h0);

        // single frame
        cs_low();
        full_frame(32'h1100_0001);
        cs_high();

        // back-to-back frames in one CS assertion
        cs_low();
        full_frame(32'h1100_0001);
        full_frame(32'h1302_7FFF);
        cs_high();
        check("b2b_number", 32'(num), 32'h1302);
        check("b2b_value", 32'(val), 32'h7FFF);

        // partial frame -> error pulse, outputs held
        exp_q.push_back({1'b1, 32'h0});
        cs_low();
        spi_bits(32'hDEAD_BEEF, 20, m);
        cs_high();
        check("partial_number", 32'(num), 32'h1302);
        check("partial_value", 32'(val), 32'h7FFF);

        // reset mid-frame with CS held low
        cs_low();
        spi_bits(32'h5555_AAAA, 10, m);
        @(negedge clk) rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        tb_last = 32'h0;
        spi_bits(32'h5555_AAAA << 10, 22, m);
        cs_high();
        check("after_reset_number", 32'(num), 32'h0);
        cs_low();
        full_frame(32'h2105_00AA);
        cs_high();
        check("rst_frame_number", 32'(num), 32'h2105);
        check("rst_frame_value", 32'(val), 32'h00AA);

        // echo of frame A during frame B
        cs_low();
        full_frame(32'hABCD_1234);
        cs_high();
        cs_low();
        full_frame(32'h0F0F_F0F0);
        cs_high();

        // random phase at SCLK = i_Clock/8
        for (int f = 0; f < 150; f++) begin
            #($urandom_range(0, 9));
            cs_low();
            full_frame($urandom);
            cs_high();
        end

        repeat (50) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
